// File: rtl/caxi4interconnect_master_addr_decode_stage_pkg.sv
// ============================================================================
// Module  : caxi4interconnect_master_addr_decode_stage_pkg
// Brief   : Shared constants and elaboration helpers for the master decode stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package caxi4interconnect_master_addr_decode_stage_pkg;

  // The DECERR pseudo-slave sits one index past the last real slave.
  function automatic int decErrIndex(input int numSlaves);
    return numSlaves;
  endfunction

  function automatic int slotWidth(input int upperBit, input int lowerBit);
    return upperBit - lowerBit;
  endfunction

  function automatic bit cntWidthOk(input int maxOutstanding, input int cntWidth);
    return (maxOutstanding >= 1) && (maxOutstanding < (1 << cntWidth));
  endfunction

  function automatic bit slaveWidthOk(input int numSlaves, input int slaveWidth);
    return (1 << slaveWidth) > numSlaves;
  endfunction

endpackage

`default_nettype wire

// File: rtl/caxi4interconnect_master_addr_decode_stage_slot_match.sv
// ============================================================================
// Module  : caxi4interconnect_slot_match
// Brief   : One inclusive address-window comparator gated by connectivity
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module caxi4interconnect_slot_match #(
  parameter int SLOT_WIDTH = 16
) (
  input  logic [SLOT_WIDTH-1:0] i_addrField,
  input  logic [SLOT_WIDTH-1:0] i_minAddr,
  input  logic [SLOT_WIDTH-1:0] i_maxAddr,
  input  logic                  i_connected,
  output logic                  o_hit
);

  assign o_hit = i_connected && (i_addrField >= i_minAddr) && (i_addrField <= i_maxAddr);

endmodule

`default_nettype wire

// File: rtl/caxi4interconnect_master_addr_decode_stage.sv
// ============================================================================
// Module  : caxi4interconnect_master_addr_decode_stage
// Brief   : Registered address decode with outstanding-count ordering stall
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module caxi4interconnect_master_addr_decode_stage
  import caxi4interconnect_master_addr_decode_stage_pkg::*;
#(
  parameter int NUM_SLAVES        = 8,
  parameter int NUM_SLAVES_WIDTH  = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int UPPER_COMPARE_BIT = 28,
  parameter int LOWER_COMPARE_BIT = 12,
  parameter logic [NUM_SLAVES*(UPPER_COMPARE_BIT-LOWER_COMPARE_BIT)-1:0] SLOT_MIN_ADDR = '0,
  parameter logic [NUM_SLAVES*(UPPER_COMPARE_BIT-LOWER_COMPARE_BIT)-1:0] SLOT_MAX_ADDR = '0,
  parameter logic [NUM_SLAVES-1:0] CONNECTIVITY = '1,
  parameter int MAX_OUTSTANDING   = 8,
  parameter int CNT_WIDTH         = 4
) (
  input  logic                        ACLK,
  input  logic                        sysReset,
  input  logic [ADDR_WIDTH-1:0]       masterAddr,
  input  logic                        masterValid,
  output logic                        masterReady,
  output logic [ADDR_WIDTH-1:0]       slaveAddr,
  output logic [NUM_SLAVES_WIDTH-1:0] slaveMatched,
  output logic                        decErr,
  output logic                        slaveValid,
  input  logic                        slaveReady,
  input  logic                        txnDone,
  output logic [CNT_WIDTH-1:0]        outstandingCnt,
  output logic                        busy
);

  localparam int c_slotW = slotWidth(UPPER_COMPARE_BIT, LOWER_COMPARE_BIT);
  localparam logic [NUM_SLAVES_WIDTH-1:0] c_decErrIdx = NUM_SLAVES_WIDTH'(decErrIndex(NUM_SLAVES));
  localparam logic [CNT_WIDTH-1:0] c_maxCnt = CNT_WIDTH'(MAX_OUTSTANDING);

  if (!slaveWidthOk(NUM_SLAVES, NUM_SLAVES_WIDTH)) begin : g_badSlaveWidth
    $fatal(1, "NUM_SLAVES_WIDTH cannot encode the DECERR slave index");
  end
  if (!cntWidthOk(MAX_OUTSTANDING, CNT_WIDTH)) begin : g_badCntWidth
    $fatal(1, "CNT_WIDTH cannot hold MAX_OUTSTANDING");
  end

  logic [c_slotW-1:0]          w_addrField;
  logic [NUM_SLAVES-1:0]       w_hits;
  logic [NUM_SLAVES_WIDTH-1:0] w_target;
  logic                        w_isDecErr;
  logic                        w_stall;
  logic                        w_accept;
  logic                        w_doneValid;
  logic [CNT_WIDTH-1:0]        w_cntNext;

  logic [ADDR_WIDTH-1:0]       r_slaveAddr;
  logic [NUM_SLAVES_WIDTH-1:0] r_slaveMatched;
  logic                        r_decErr;
  logic                        r_slaveValid;
  logic [NUM_SLAVES_WIDTH-1:0] r_curSlave;
  logic [CNT_WIDTH-1:0]        r_cnt;

  assign w_addrField = masterAddr[UPPER_COMPARE_BIT-1:LOWER_COMPARE_BIT];

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slot
    caxi4interconnect_slot_match #(
      .SLOT_WIDTH (c_slotW)
    ) u_slotMatch (
      .i_addrField (w_addrField),
      .i_minAddr   (SLOT_MIN_ADDR[i*c_slotW +: c_slotW]),
      .i_maxAddr   (SLOT_MAX_ADDR[i*c_slotW +: c_slotW]),
      .i_connected (CONNECTIVITY[i]),
      .o_hit       (w_hits[i])
    );
  end

  // Scan downward so the lowest-index hit is the last assignment and wins.
  always_comb begin
    w_target = c_decErrIdx;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hits[i]) w_target = NUM_SLAVES_WIDTH'(i);
    end
  end

  assign w_isDecErr = ~|w_hits;

  // A target switch waits for full drain so responses return in request order.
  assign w_stall     = (r_cnt == c_maxCnt) || ((r_cnt != '0) && (w_target != r_curSlave));
  assign masterReady = (!r_slaveValid || slaveReady) && !w_stall;
  assign w_accept    = masterValid && masterReady;
  assign w_doneValid = txnDone && (r_cnt != '0);

  always_comb begin
    w_cntNext = r_cnt;
    case ({w_accept, w_doneValid})
      2'b10:   w_cntNext = r_cnt + 1'b1;
      2'b01:   w_cntNext = r_cnt - 1'b1;
      default: w_cntNext = r_cnt;
    endcase
  end

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      r_slaveAddr    <= '0;
      r_slaveMatched <= '0;
      r_decErr       <= 1'b0;
      r_slaveValid   <= 1'b0;
      r_curSlave     <= '0;
      r_cnt          <= '0;
    end else begin
      r_cnt <= w_cntNext;
      if (w_accept) begin
        r_slaveAddr    <= masterAddr;
        r_slaveMatched <= w_target;
        r_decErr       <= w_isDecErr;
        r_slaveValid   <= 1'b1;
        r_curSlave     <= w_target;
      end else if (slaveReady) begin
        r_slaveValid <= 1'b0;
      end
    end
  end

  assign slaveAddr      = r_slaveAddr;
  assign slaveMatched   = r_slaveMatched;
  assign decErr         = r_decErr;
  assign slaveValid     = r_slaveValid;
  assign outstandingCnt = r_cnt;
  assign busy           = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_caxi4interconnect_master_addr_decode_stage.sv
// ============================================================================
// Module  : tb_caxi4interconnect_master_addr_decode_stage
// Brief   : Directed self-checking bench for the master address decode stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_caxi4interconnect_master_addr_decode_stage;

  localparam int c_ns = 4;
  localparam logic [63:0] c_min = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
  localparam logic [63:0] c_max = {16'h03FF, 16'h02FF, 16'h01FF, 16'h00FF};

  logic        ACLK = 1'b0;
  logic        sysReset = 1'b1;
  logic [31:0] masterAddr = '0;
  logic        masterValid = 1'b0;
  logic        slaveReady = 1'b1;
  logic        txnDone = 1'b0;

  logic        aReady, aValid, aDecErr, aBusy;
  logic [31:0] aAddr;
  logic [3:0]  aMatched, aCnt;
  logic        bReady, bValid, bDecErr, bBusy;
  logic [31:0] bAddr;
  logic [3:0]  bMatched, bCnt;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  caxi4interconnect_master_addr_decode_stage #(
    .NUM_SLAVES(c_ns), .NUM_SLAVES_WIDTH(4), .ADDR_WIDTH(32),
    .UPPER_COMPARE_BIT(28), .LOWER_COMPARE_BIT(12),
    .SLOT_MIN_ADDR(c_min), .SLOT_MAX_ADDR(c_max),
    .CONNECTIVITY(4'b1111), .MAX_OUTSTANDING(2), .CNT_WIDTH(4)
  ) dutA (
    .ACLK(ACLK), .sysReset(sysReset), .masterAddr(masterAddr),
    .masterValid(masterValid), .masterReady(aReady), .slaveAddr(aAddr),
    .slaveMatched(aMatched), .decErr(aDecErr), .slaveValid(aValid),
    .slaveReady(slaveReady), .txnDone(txnDone), .outstandingCnt(aCnt), .busy(aBusy)
  );

  caxi4interconnect_master_addr_decode_stage #(
    .NUM_SLAVES(c_ns), .NUM_SLAVES_WIDTH(4), .ADDR_WIDTH(32),
    .UPPER_COMPARE_BIT(28), .LOWER_COMPARE_BIT(12),
    .SLOT_MIN_ADDR(c_min), .SLOT_MAX_ADDR(c_max),
    .CONNECTIVITY(4'b1101), .MAX_OUTSTANDING(8), .CNT_WIDTH(4)
  ) dutB (
    .ACLK(ACLK), .sysReset(sysReset), .masterAddr(masterAddr),
    .masterValid(masterValid), .masterReady(bReady), .slaveAddr(bAddr),
    .slaveMatched(bMatched), .decErr(bDecErr), .slaveValid(bValid),
    .slaveReady(slaveReady), .txnDone(txnDone), .outstandingCnt(bCnt), .busy(bBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", 32'(aValid), 32'd0);
    check("rst_addr", aAddr, 32'd0);
    check("rst_matched", 32'(aMatched), 32'd0);
    check("rst_decerr", 32'(aDecErr), 32'd0);
    check("rst_cnt", 32'(aCnt), 32'd0);
    check("rst_busy", 32'(aBusy), 32'd0);
    sysReset = 1'b0;
    step();

    // Hit and one-cycle latency; dutB has slot1 disconnected
    masterAddr = 32'h0010_5000; masterValid = 1'b1;
    #1;
    check("hit_ready", 32'(aReady), 32'd1);
    step();
    masterValid = 1'b0;
    check("hit_valid", 32'(aValid), 32'd1);
    check("hit_matched", 32'(aMatched), 32'd1);
    check("hit_decerr", 32'(aDecErr), 32'd0);
    check("hit_addr", aAddr, 32'h0010_5000);
    check("hit_cnt", 32'(aCnt), 32'd1);
    check("hit_busy", 32'(aBusy), 32'd1);
    check("conn_matched", 32'(bMatched), 32'd4);
    check("conn_decerr", 32'(bDecErr), 32'd1);
    txnDone = 1'b1;
    step();
    txnDone = 1'b0;
    check("hit_valid_clr", 32'(aValid), 32'd0);
    check("hit_drain", 32'(aCnt), 32'd0);

    // Unmapped address
    masterAddr = 32'h0040_0000; masterValid = 1'b1;
    step();
    masterValid = 1'b0;
    check("miss_matched", 32'(aMatched), 32'd4);
    check("miss_decerr", 32'(aDecErr), 32'd1);
    check("miss_cnt", 32'(aCnt), 32'd1);
    txnDone = 1'b1;
    step();
    txnDone = 1'b0;
    check("miss_drain", 32'(aCnt), 32'd0);

    // Backpressure with a second request pending
    slaveReady = 1'b0;
    masterAddr = 32'h0020_0000; masterValid = 1'b1;
    step();
    masterAddr = 32'h0020_4000;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(aReady), 32'd0);
      check("bp_addr", aAddr, 32'h0020_0000);
      check("bp_valid", 32'(aValid), 32'd1);
      step();
    end
    slaveReady = 1'b1;
    #1;
    check("bp_release_ready", 32'(aReady), 32'd1);
    step();
    masterValid = 1'b0;
    check("bp_second_addr", aAddr, 32'h0020_4000);
    check("bp_second_matched", 32'(aMatched), 32'd2);
    check("bp_cnt", 32'(aCnt), 32'd2);
    step();
    check("bp_valid_clr", 32'(aValid), 32'd0);
    txnDone = 1'b1;
    step();
    step();
    txnDone = 1'b0;
    check("bp_drain", 32'(aCnt), 32'd0);

    // Limit, simultaneous accept/done, and slave switch
    masterValid = 1'b1;
    masterAddr = 32'h0000_1000;
    step();
    masterAddr = 32'h0000_2000;
    step();
    check("lim_cnt2", 32'(aCnt), 32'd2);
    masterAddr = 32'h0000_3000;
    #1;
    check("lim_ready", 32'(aReady), 32'd0);
    step();
    check("lim_held_addr", aAddr, 32'h0000_2000);
    check("lim_held_cnt", 32'(aCnt), 32'd2);
    txnDone = 1'b1;
    step();
    check("lim_after_done", 32'(aCnt), 32'd1);
    check("sim_ready", 32'(aReady), 32'd1);
    step();
    txnDone = 1'b0;
    check("sim_cnt", 32'(aCnt), 32'd1);
    check("sim_addr", aAddr, 32'h0000_3000);
    masterAddr = 32'h0010_5000;
    #1;
    check("sw_stall", 32'(aReady), 32'd0);
    txnDone = 1'b1;
    step();
    txnDone = 1'b0;
    check("sw_not_yet", 32'(aMatched), 32'd0);
    check("sw_cnt0", 32'(aCnt), 32'd0);
    check("sw_ready", 32'(aReady), 32'd1);
    step();
    masterValid = 1'b0;
    check("sw_matched", 32'(aMatched), 32'd1);
    check("sw_cnt", 32'(aCnt), 32'd1);
    txnDone = 1'b1;
    step();
    check("done_drain", 32'(aCnt), 32'd0);
    step();
    txnDone = 1'b0;
    check("done_at_zero", 32'(aCnt), 32'd0);

    // Asynchronous reset while a request is stalled
    slaveReady = 1'b0;
    masterAddr = 32'h0020_0000; masterValid = 1'b1;
    step();
    masterAddr = 32'h0030_0000;
    #1;
    check("rst2_pre_stall", 32'(aReady), 32'd0);
    sysReset = 1'b1;
    #1;
    check("rst2_valid", 32'(aValid), 32'd0);
    check("rst2_addr", aAddr, 32'd0);
    check("rst2_matched", 32'(aMatched), 32'd0);
    check("rst2_decerr", 32'(aDecErr), 32'd0);
    check("rst2_cnt", 32'(aCnt), 32'd0);
    check("rst2_busy", 32'(aBusy), 32'd0);
    masterValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/caxi4interconnect_master_addr_decode_stage.md
# caxi4interconnect_master_addr_decode_stage

Registered, multi-slave address decode stage for one master's AW or AR channel in the AXI4 crossbar. It decodes the master address against NUM_SLAVES configurable windows in one cycle. It forwards the request through a valid/ready register slice carrying the encoded target, or the DECERR slave on a miss. It also counts outstanding transactions and stalls a slave switch until the previous slave has drained, preserving per-master response ordering.

## Interface
Parameters:
- NUM_SLAVES, 8, number of real slaves; DECERR slave index = NUM_SLAVES
- NUM_SLAVES_WIDTH, 4, width of encoded slave number; must satisfy 2^NUM_SLAVES_WIDTH > NUM_SLAVES
- ADDR_WIDTH, 32, master address width
- UPPER_COMPARE_BIT, 28, exclusive upper bit of the compared slot field
- LOWER_COMPARE_BIT, 12, lowest compared bit; bits below are don't-care
- SLOT_MIN_ADDR, 0, flattened NUM_SLAVES×(UPPER−LOWER) vector; slot i minimum at slice i
- SLOT_MAX_ADDR, 0, flattened vector in the same layout; slot i maximum, inclusive
- CONNECTIVITY, all ones, NUM_SLAVES bits; bit i = 1 means this master may access slave i
- MAX_OUTSTANDING, 8, outstanding transaction limit, ≥ 1
- CNT_WIDTH, 4, counter width; must hold MAX_OUTSTANDING

Ports:
- ACLK  in  1  clock, all state on rising edge
- sysReset  in  1  asynchronous, active-high reset
- masterAddr  in  ADDR_WIDTH  request address
- masterValid  in  1  request valid
- masterReady  out  1  request accepted when high with masterValid
- slaveAddr  out  ADDR_WIDTH  registered address
- slaveMatched  out  NUM_SLAVES_WIDTH  registered target slave number
- decErr  out  1  registered target is the DECERR slave
- slaveValid  out  1  output stage holds a request
- slaveReady  in  1  downstream accepts
- txnDone  in  1  one-cycle pulse per completed transaction (last response handshake)
- outstandingCnt  out  CNT_WIDTH  current outstanding count
- busy  out  1  outstandingCnt != 0

## Operation
- Decode: slot i hits when min_i ≤ masterAddr[UPPER−1:LOWER] ≤ max_i and CONNECTIVITY[i] = 1. The lowest-index hit wins on overlapping windows.
- No hit: target = NUM_SLAVES, and decErr is set in the stage.
- Stall is asserted when either holds:
  - outstandingCnt == MAX_OUTSTANDING;
  - outstandingCnt != 0 and the decoded target != curSlave.
- masterReady = (!slaveValid | slaveReady) & !stall. It depends combinationally on masterAddr and stage state, but never on masterValid.
- Accept (masterValid & masterReady):
  - load slaveAddr, slaveMatched and decErr;
  - set slaveValid;
  - set curSlave to the decoded target.
- Output handshake with no new accept clears slaveValid. Data outputs hold until the next accept.
- While slaveValid & !slaveReady, all outputs are held stable.
- Counter:
  - +1 on accept;
  - −1 on txnDone;
  - both in the same cycle: unchanged;
  - txnDone at 0 is ignored and the count stays 0.
- DECERR targets are counted like any slave. Switching between DECERR and a real slave also waits for drain.

## Timing
- Reset values:
  - slaveValid = 0, slaveAddr = 0, slaveMatched = 0, decErr = 0;
  - outstandingCnt = 0, busy = 0, curSlave = 0.
- masterReady becomes valid after reset release.
- Latency: accept in cycle N produces slaveValid in cycle N+1. Back-to-back accepts give full throughput when slaveReady stays high.
- A stall lifts the cycle after the count reaches 0. The new target is accepted in that cycle at the earliest.
- Reset mid-operation clears the stage and the counter immediately. In-flight requests are discarded.

## Structure
- Shared package holds:
  - the DECERR index constant, computed as NUM_SLAVES;
  - the slot-slice width function, UPPER−LOWER;
  - counter-width and NUM_SLAVES_WIDTH legality checks.
- Sub-module caxi4interconnect_slot_match is one window comparator: address field, min, max and connectivity bit in; hit out. It is generated NUM_SLAVES times, followed by a priority encoder in this block.

## Test plan
- Setup for all tests: NUM_SLAVES=4, windows slot0 0x0000–0x00FF, slot1 0x0100–0x01FF, others disjoint.
- Hit and latency: addr 0x0010_5000 with slaveReady=1 → slaveValid in the next cycle, slaveMatched=1, decErr=0, outstandingCnt=1.
- Miss and connectivity: unmapped addr → slaveMatched=4, decErr=1. With CONNECTIVITY=4'b1101, a slot1 address also gives DECERR.
- Backpressure: slaveReady=0 for 3 cycles with a second request pending → masterReady=0, outputs stable. Release → both delivered in order.
- Slave switch: 2 requests to slot0, then a request to slot1 → slot1 stalls until 2 txnDone pulses. It is accepted the cycle after the count hits 0.
- Limit and simultaneous events:
  - MAX_OUTSTANDING=2, third same-slave request → stalled until a txnDone;
  - accept together with txnDone → count unchanged;
  - txnDone at count 0 → count stays 0;
  - sysReset mid-stall → all outputs at reset values.
